// File: rtl/disp_scanout_if.sv
// rtl/disp_scanout_if.sv - read-only memory port between the scanout engine and the system arbiter
//
// Signals:
//   req    : read request, held with addr until ack
//   addr   : word address
//   wr     : write strobe (always 0 from the scanout side)
//   ack    : request accepted this cycle
//   rvalid : read data valid, returned in request order
//   rdata  : read data
interface disp_scanout_if #(
    parameter int AN = 24,
    parameter int DN = 16
);
    logic          req;
    logic [AN-1:0] addr;
    logic          wr;
    logic          ack;
    logic          rvalid;
    logic [DN-1:0] rdata;

    modport master (
        output req, addr, wr,
        input  ack, rvalid, rdata
    );

    modport slave (
        input  req, addr, wr,
        output ack, rvalid, rdata
    );
endinterface

// File: rtl/disp_scanout.sv
// rtl/disp_scanout.sv - framebuffer scanout: raster timing, front-buffer fetch FIFO, buffer swap
//
// Ports:
//   clkSYS    : system clock (sole clock)
//   reset     : asynchronous active-high reset
//   mem       : memory read port (master side of disp_scanout_if)
//   swap      : requested front buffer (level, sampled at the frame boundary)
//   stat      : buffer currently being displayed
//   hsync     : active-low horizontal sync
//   vsync     : active-low vertical sync
//   de        : data enable
//   rgb       : RGB565 pixel data
//   underflow : sticky FIFO underflow flag
module disp_scanout #(
    parameter int          AN     = 24,
    parameter int          DN     = 16,
    parameter int unsigned BASE   = 0,
    parameter int unsigned SWAP   = 'h80000,
    parameter int          W      = 800,
    parameter int          H      = 480,
    parameter int          HFP    = 40,
    parameter int          HS     = 48,
    parameter int          HBP    = 40,
    parameter int          VFP    = 13,
    parameter int          VS     = 3,
    parameter int          VBP    = 29,
    parameter int          CLKDIV = 4,
    parameter int          DEPTH  = 16
) (
    input  logic           clkSYS,
    input  logic           reset,
    disp_scanout_if.master mem,
    input  logic           swap,
    output logic           stat,
    output logic           hsync,
    output logic           vsync,
    output logic           de,
    output logic [DN-1:0]  rgb,
    output logic           underflow
);

    localparam int HT   = W + HFP + HS + HBP;
    localparam int VT   = H + VFP + VS + VBP;
    localparam int HW   = $clog2(HT);
    localparam int VW   = $clog2(VT);
    localparam int DIVW = $clog2(CLKDIV);
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = PW + 1;
    localparam int RW   = $clog2(W * H + 1);

    localparam logic [HW-1:0]   H_ACT  = HW'(W);
    localparam logic [HW-1:0]   H_SS   = HW'(W + HFP);
    localparam logic [HW-1:0]   H_SE   = HW'(W + HFP + HS);
    localparam logic [HW-1:0]   H_LAST = HW'(HT - 1);
    localparam logic [VW-1:0]   V_ACT  = VW'(H);
    localparam logic [VW-1:0]   V_SS   = VW'(H + VFP);
    localparam logic [VW-1:0]   V_SE   = VW'(H + VFP + VS);
    localparam logic [VW-1:0]   V_LAST = VW'(VT - 1);
    localparam logic [DIVW-1:0] D_LAST = DIVW'(CLKDIV - 1);
    localparam logic [CW-1:0]   FDEPTH = CW'(DEPTH);
    localparam logic [RW-1:0]   NPIX   = RW'(W * H);
    localparam logic [AN-1:0]   ADDR0  = AN'(BASE);
    localparam logic [AN-1:0]   ADDR1  = AN'(BASE + SWAP);

    typedef enum logic [1:0] {
        S_FLUSH,
        S_FETCH,
        S_DONE
    } state_t;

    state_t          state;
    logic [DIVW-1:0] div_q;
    logic [HW-1:0]   hcnt;
    logic [VW-1:0]   vcnt;
    logic            req_q;
    logic [AN-1:0]   addr_q;
    logic [RW-1:0]   rem;
    logic [CW-1:0]   pending;
    logic [CW-1:0]   fifo_cnt;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [DN-1:0]   fifo_mem [DEPTH];

    logic          pen;
    logic          active;
    logic          frame_start;
    logic          acc;
    logic          dec;
    logic          push;
    logic          pop;
    logic          fifo_empty;
    logic          flush_exit;
    logic [CW-1:0] free;

    assign pen         = (div_q == D_LAST);
    assign active      = (hcnt < H_ACT) && (vcnt < V_ACT);
    // Start of vsync is the one frame boundary: everything restarts from Flush here.
    assign frame_start = pen && (hcnt == '0) && (vcnt == V_SS);

    assign acc        = req_q && mem.ack;
    assign dec        = mem.rvalid && (pending != '0);
    // Data still in flight when Flush began belongs to the old frame and is dropped.
    assign push       = dec && (state != S_FLUSH);
    assign fifo_empty = (fifo_cnt == '0);
    assign pop        = pen && active && !fifo_empty;
    // Outstanding reads already own a FIFO slot, so they count against free space.
    assign free       = FDEPTH - fifo_cnt - pending;
    // A held request must complete before the new frame can start fetching.
    assign flush_exit = (state == S_FLUSH) && !req_q && (pending == '0);

    assign mem.req  = req_q;
    assign mem.addr = addr_q;
    assign mem.wr   = 1'b0;

    always_ff @(posedge clkSYS or posedge reset) begin
        if (reset) begin
            div_q <= '0;
            hcnt  <= '0;
            vcnt  <= '0;
        end else begin
            div_q <= pen ? '0 : div_q + 1'b1;
            if (pen) begin
                if (hcnt == H_LAST) begin
                    hcnt <= '0;
                    vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
                end else begin
                    hcnt <= hcnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clkSYS or posedge reset) begin
        if (reset) begin
            de        <= 1'b0;
            hsync     <= 1'b1;
            vsync     <= 1'b1;
            rgb       <= '0;
            underflow <= 1'b0;
        end else if (pen) begin
            de    <= active;
            hsync <= !((hcnt >= H_SS) && (hcnt < H_SE));
            vsync <= !((vcnt >= V_SS) && (vcnt < V_SE));
            if (active) begin
                // An empty FIFO still consumes the pixel slot so raster timing never slips.
                rgb <= fifo_empty ? '0 : fifo_mem[rd_ptr];
                if (fifo_empty) begin
                    underflow <= 1'b1;
                end
            end else begin
                rgb <= '0;
            end
        end
    end

    always_ff @(posedge clkSYS) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem.rdata;
        end
    end

    always_ff @(posedge clkSYS or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else if (flush_exit) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clkSYS or posedge reset) begin
        if (reset) begin
            state   <= S_FLUSH;
            req_q   <= 1'b0;
            addr_q  <= '0;
            rem     <= '0;
            pending <= '0;
            stat    <= 1'b0;
        end else begin
            case ({acc, dec})
                2'b10:   pending <= pending + 1'b1;
                2'b01:   pending <= pending - 1'b1;
                default: pending <= pending;
            endcase

            if (acc) begin
                addr_q <= addr_q + 1'b1;
                rem    <= rem - 1'b1;
            end

            // A raised request is never withdrawn. Otherwise keep streaming back to back
            // as long as words remain and a slot is left after the one accepted now.
            if (req_q && !mem.ack) begin
                req_q <= 1'b1;
            end else begin
                req_q <= (state == S_FETCH) && !frame_start &&
                         (rem != RW'(acc)) && (free > CW'(acc));
            end

            case (state)
                S_FLUSH: begin
                    if (flush_exit) begin
                        stat   <= swap;
                        addr_q <= swap ? ADDR1 : ADDR0;
                        rem    <= NPIX;
                        state  <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (acc && (rem == RW'(1))) begin
                        state <= S_DONE;
                    end
                end
                default: begin
                    state <= state;
                end
            endcase

            if (frame_start) begin
                state <= S_FLUSH;
            end
        end
    end

endmodule

// File: tb/tb_disp_scanout.sv
// tb/tb_disp_scanout.sv - scoreboard bench for disp_scanout on a tiny 8x4 raster
module tb_disp_scanout;

    localparam int AN     = 24;
    localparam int DN     = 16;
    localparam int W      = 8;
    localparam int H      = 4;
    localparam int HT     = 11;
    localparam int VT     = 7;
    localparam int BASE   = 0;
    localparam int SWAP   = 'h80040;
    localparam int BUDGET = 4000;

    logic          clkSYS = 1'b0;
    logic          reset  = 1'b1;
    logic          swap   = 1'b0;
    logic          stat;
    logic          hsync;
    logic          vsync;
    logic          de;
    logic [DN-1:0] rgb;
    logic          underflow;
    logic          ack_en = 1'b1;
    int            lat    = 1;

    disp_scanout_if #(.AN(AN), .DN(DN)) bus ();

    assign bus.ack = bus.req & ack_en;

    disp_scanout #(
        .AN(AN), .DN(DN), .BASE(BASE), .SWAP(SWAP),
        .W(W), .H(H), .HFP(1), .HS(1), .HBP(1),
        .VFP(1), .VS(1), .VBP(1), .CLKDIV(2), .DEPTH(16)
    ) dut (
        .clkSYS    (clkSYS),
        .reset     (reset),
        .mem       (bus),
        .swap      (swap),
        .stat      (stat),
        .hsync     (hsync),
        .vsync     (vsync),
        .de        (de),
        .rgb       (rgb),
        .underflow (underflow)
    );

    always #5 clkSYS = ~clkSYS;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        int          fr;
        int          idx;
        logic [15:0] val;
    } exp_t;
    exp_t sb[$];

    task automatic push_frame(input int fr, input int first, input bit zeros, input int n);
        for (int i = 0; i < n; i++) begin
            sb.push_back('{fr, i, zeros ? 16'h0 : 16'(first + i)});
        end
    endtask

    // Memory model: in-order returns, per-request latency stamped at acceptance.
    typedef struct {
        int            due;
        logic [AN-1:0] a;
    } mreq_t;
    mreq_t mq[$];
    int    cyc = 0;

    initial begin
        bus.rvalid = 1'b0;
        bus.rdata  = '0;
        forever begin
            @(negedge clkSYS);
            cyc++;
            if (reset) begin
                mq.delete();
                bus.rvalid = 1'b0;
                bus.rdata  = '0;
            end else begin
                if (mq.size() > 0 && mq[0].due <= cyc) begin
                    bus.rvalid = 1'b1;
                    bus.rdata  = mq[0].a[15:0];
                    void'(mq.pop_front());
                end else begin
                    bus.rvalid = 1'b0;
                    bus.rdata  = '0;
                end
                if (bus.req && bus.ack) begin
                    mq.push_back('{cyc + lat, bus.addr});
                end
            end
        end
    end

    // Monitor: independent raster model; nh/nv/nf = position of the next pixel,
    // ch/cv/cf = position of the pixel just compared.
    int nh = 0, nv = 0, nf = 0;
    int ch = -1, cv = -1, cf = -1;
    int ph = 0;
    bit in_rst = 1'b0;

    task automatic check_pixel();
        bit act;
        int idx;
        act = (nh < W) && (nv < H);
        check("timing", 32'({de, hsync, vsync}), 32'({act, nh != 9, nv != 5}));
        if (!act) begin
            check("blank_rgb", 32'(rgb), 32'h0);
        end else begin
            idx = nv * W + nh;
            while (sb.size() > 0 && sb[0].fr < nf) begin
                check("sb_order", 32'(sb[0].fr), 32'(nf));
                void'(sb.pop_front());
            end
            if (sb.size() > 0 && sb[0].fr == nf && sb[0].idx == idx) begin
                check($sformatf("rgb_f%0d_i%0d", nf, idx), 32'(rgb), 32'(sb[0].val));
                void'(sb.pop_front());
            end
        end
        cf = nf; cv = nv; ch = nh;
        nh++;
        if (nh == HT) begin
            nh = 0;
            nv++;
            if (nv == VT) begin
                nv = 0;
                nf++;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clkSYS);
            if (reset) begin
                if (!in_rst) begin
                    nf++;
                    in_rst = 1'b1;
                end
                nh = 0; nv = 0; ph = 0;
            end else begin
                in_rst = 1'b0;
                ph++;
                if (ph % 2 == 0) begin
                    @(negedge clkSYS);
                    if (!reset) check_pixel();
                end
            end
        end
    end

    task automatic wait_at(input int f, input int v, input int h);
        int n = 0;
        while (!(cf == f && cv == v && ch == h) && n < BUDGET) begin
            @(posedge clkSYS);
            #1;
            n++;
        end
        if (!(cf == f && cv == v && ch == h)) begin
            checks++;
            failures++;
            $display("FAIL wait_at actual=f%0d/v%0d/h%0d required=f%0d/v%0d/h%0d", cf, cv, ch, f, v, h);
        end
    endtask

    task automatic wait_req(output logic [AN-1:0] a);
        int n = 0;
        while (bus.req !== 1'b1 && n < 40) begin
            @(posedge clkSYS);
            #1;
            n++;
        end
        check("req_rise", 32'(bus.req), 32'h1);
        a = bus.addr;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"}, 32'(bus.req), 32'h0);
        check({tag, "_addr"}, 32'(bus.addr), 32'h0);
        check({tag, "_hsync"}, 32'(hsync), 32'h1);
        check({tag, "_vsync"}, 32'(vsync), 32'h1);
        check({tag, "_de"}, 32'(de), 32'h0);
        check({tag, "_rgb"}, 32'(rgb), 32'h0);
        check({tag, "_stat"}, 32'(stat), 32'h0);
        check({tag, "_underflow"}, 32'(underflow), 32'h0);
    endtask

    initial begin
        logic [AN-1:0] a;
        logic [AN-1:0] cap;
        int            bad;

        push_frame(1, 0, 1'b1, 1);
        push_frame(2, 0, 1'b0, 32);
        push_frame(3, 'h40, 1'b0, 32);
        push_frame(4, 0, 1'b1, 32);
        push_frame(6, 'h40, 1'b0, 32);
        push_frame(7, 0, 1'b1, 32);
        push_frame(8, 0, 1'b0, 32);

        repeat (3) @(posedge clkSYS);
        #1;
        check_reset_outputs("reset");
        check("wr_const", 32'(bus.wr), 32'h0);
        @(negedge clkSYS);
        reset = 1'b0;

        wait_req(a);
        check("first_req_addr", 32'(a), 32'(BASE));
        wait_at(1, 0, 0);
        check("uf_first_pixel", 32'(underflow), 32'h1);

        wait_at(2, 1, 0);
        swap = 1'b1;
        wait_at(2, 4, 0);
        check("stat_before_flush", 32'(stat), 32'h0);
        wait_at(3, 0, 0);
        check("stat_after_flush", 32'(stat), 32'h1);

        wait_at(3, 4, 0);
        ack_en = 1'b0;
        wait_at(3, 5, 0);
        wait_req(cap);
        check("held_addr_base1", 32'(cap), 32'h080040);
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clkSYS);
            #1;
            if (!(bus.req === 1'b1 && bus.addr === cap)) bad++;
        end
        check("held_req_stable", 32'(bad), 32'h0);
        ack_en = 1'b1;

        wait_at(6, 3, 7);
        check("uf_sticky", 32'(underflow), 32'h1);
        wait_at(6, 4, 0);
        ack_en = 1'b0;

        wait_at(7, 4, 0);
        lat    = 30;
        ack_en = 1'b1;
        repeat (3) @(posedge clkSYS);
        #1;
        ack_en = 1'b0;
        lat    = 1;
        swap   = 1'b0;
        wait_at(7, 5, 0);
        check("pending_at_boundary", 32'(mq.size()), 32'h3);
        check("req_held_boundary", 32'(bus.req), 32'h1);
        check("held_addr_boundary", 32'(bus.addr), 32'h080043);
        ack_en = 1'b1;
        wait_at(8, 0, 0);
        check("stat_back_to_0", 32'(stat), 32'h0);

        wait_at(8, 1, 3);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        repeat (4) @(posedge clkSYS);
        while (sb.size() > 0 && sb[0].fr == 8) void'(sb.pop_front());
        push_frame(9, 0, 1'b1, 1);
        push_frame(10, 0, 1'b0, 32);
        @(negedge clkSYS);
        reset = 1'b0;
        wait_req(a);
        check("rst_first_req_addr", 32'(a), 32'(BASE));
        wait_at(9, 0, 0);
        check("uf_after_reset", 32'(underflow), 32'h1);

        wait_at(10, 4, 0);
        check("sb_drained", 32'(sb.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
